alu_host_cmd_sender: RTL and testbench
======================================

// Module: alu_host_cmd_sender
// PURPOSE
//  Host-side counterpart of the UART/ALU interface FSM. Accepts one ALU command (op, A, B) on a
//  valid/ready handshake, writes it as three bytes (OP, A, B) into the TX FIFO, then pops one result
//  byte from the RX FIFO. Returns the result with a one-cycle valid pulse, or a timeout flag.
//  Used as the on-board self-test master and as the bench-side driver of the UART link.
// PARAMETERS
//  NB_DATA          8      FIFO byte width; width of A, B and result
//  NB_OP            6      opcode width, NB_OP <= NB_DATA
//  NB_TIMEOUT       16     width of the wait-for-result counter
//  TIMEOUT_CYCLES   50000  cycles spent in WAIT_RES before giving up, range 1..2^NB_TIMEOUT-1
// PORTS
//  i_clk          in   1        clock
//  i_reset        in   1        synchronous active-high reset
//  i_cmd_valid    in   1        command present
//  o_cmd_ready    out  1        command accepted on valid&ready
//  i_cmd_op       in   NB_OP    opcode
//  i_cmd_a        in   NB_DATA  operand A
//  i_cmd_b        in   NB_DATA  operand B
//  o_tx_wr        out  1        TX FIFO push strobe
//  o_tx_wr_data   out  NB_DATA  TX FIFO push data
//  i_tx_full      in   1        TX FIFO full
//  o_rx_rd        out  1        RX FIFO pop strobe
//  i_rx_data      in   NB_DATA  RX FIFO head, first-word-fall-through, valid when ~i_rx_empty
//  i_rx_empty     in   1        RX FIFO empty
//  o_res_valid    out  1        1-cycle pulse: o_res_data holds a new result
//  o_res_data     out  NB_DATA  last received result, held
//  o_res_timeout  out  1        1-cycle pulse: no result within TIMEOUT_CYCLES
//  o_timeout_cnt  out  8        saturating count of timeouts since reset
//  o_busy         out  1        state != IDLE
// BEHAVIOUR
//  States: IDLE, SEND_OP, SEND_A, SEND_B, WAIT_RES.
//  Reset: state IDLE, latched op/A/B = 0, o_res_data = 0, o_res_valid = o_res_timeout = 0,
//   o_timeout_cnt = 0, wait counter = 0. While i_reset = 1, o_tx_wr and o_rx_rd are forced to 0.
//  o_cmd_ready = (IDLE & i_rx_empty) is combinational. Stale RX bytes must be flushed first.
//  IDLE with ~i_rx_empty: o_rx_rd = 1, byte is discarded, no result pulse.
//  IDLE with valid&ready: latch op/A/B, go to SEND_OP next edge.
//  SEND_x: o_tx_wr = ~i_tx_full, combinational. o_tx_wr_data = SEND_OP:{0s,op}, SEND_A:A, SEND_B:B.
//   Advance SEND_OP->SEND_A->SEND_B->WAIT_RES only in a cycle where o_tx_wr = 1.
//   While full, stay in the state; no write, no byte lost or duplicated.
//  WAIT_RES: counter is cleared on entry and increments each cycle the RX FIFO is empty.
//   ~i_rx_empty: o_rx_rd = 1; next edge o_res_data <= i_rx_data, o_res_valid = 1, go to IDLE.
//   Empty with counter == TIMEOUT_CYCLES-1: next edge o_res_timeout = 1, o_timeout_cnt += 1
//    (saturates at 255), go to IDLE; o_res_data unchanged.
//   Data and timeout in the same cycle: data wins, no timeout.
//  o_res_valid and o_res_timeout are registered and never 1 together.
//  Minimum latency, TX never full and result already queued: accept at edge 0; writes in cycles 1,2,3;
//   pop in cycle 4; o_res_valid in cycle 5; o_cmd_ready back in cycle 5.
//  Reset mid-command: IDLE on the next edge, no further TX writes. A partial command already in TX is
//   not recalled; a later stale result is flushed in IDLE.
//  o_tx_wr/o_rx_rd are never 1 while the corresponding full/empty input is 1.
// STRUCTURE
//  Shared header: state codes; ALU opcode constants (ADD=6'h20, SUB=6'h22, AND=6'h24, OR=6'h25,
//   XOR=6'h26, SRA=6'h03, SRL=6'h02, NOR=6'h27), shared with the ALU and the interface FSM.
//  One sub-module: timeout_counter (clear, enable, terminal-count flag, parameterised NB_TIMEOUT).
//  Rest is one FSM with registered state and data, and combinational strobes.
// TESTING
//  1 ADD A=0x05 B=0x03, FIFOs idle, responder model returns 0x08 -> TX bytes 0x20,0x05,0x03 in 3
//    consecutive cycles; o_res_valid one cycle, o_res_data=0x08, 5 cycles from accept.
//  2 i_tx_full high 4 cycles during SEND_A (SUB 0x10,0x01) -> A written exactly once after full drops;
//    byte order 0x22,0x10,0x01; result 0x0F.
//  3 No response, TIMEOUT_CYCLES=16 -> o_res_timeout pulse 16 cycles after WAIT_RES entry;
//    o_timeout_cnt=1; o_res_data unchanged; o_cmd_ready=1 next cycle.
//  4 Two stale bytes in RX while IDLE, i_cmd_valid high -> both popped, o_cmd_ready low meanwhile,
//    no o_res_valid; command accepted the cycle after RX empties.
//  5 Result byte arrives in the terminal-count cycle -> o_res_valid=1, o_res_timeout stays 0.
//  6 i_reset asserted in SEND_A -> no further o_tx_wr; IDLE with o_busy=0 next cycle; new command completes.

Source files
------------

// File: rtl/alu_host_cmd_sender_pkg.sv
// Shared definitions for the host command sender: FSM state codes and the ALU
// opcode map common to the ALU and the UART interface FSM.
package alu_host_cmd_sender_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_OP,
        ST_SEND_A,
        ST_SEND_B,
        ST_WAIT_RES
    } state_e;

    localparam logic [5:0] ALU_OP_ADD = 6'h20;
    localparam logic [5:0] ALU_OP_SUB = 6'h22;
    localparam logic [5:0] ALU_OP_AND = 6'h24;
    localparam logic [5:0] ALU_OP_OR  = 6'h25;
    localparam logic [5:0] ALU_OP_XOR = 6'h26;
    localparam logic [5:0] ALU_OP_SRA = 6'h03;
    localparam logic [5:0] ALU_OP_SRL = 6'h02;
    localparam logic [5:0] ALU_OP_NOR = 6'h27;

endpackage

// File: rtl/alu_host_cmd_sender_timeout_counter.sv
// Wait-for-result counter: clear has priority over enable; the terminal flag is
// raised while the count equals TIMEOUT_CYCLES-1.
module timeout_counter #(
    parameter int unsigned NB_TIMEOUT     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam logic [NB_TIMEOUT-1:0] LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    logic [NB_TIMEOUT-1:0] count_q;
    logic [NB_TIMEOUT-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable) begin
            count_d = count_q + NB_TIMEOUT'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_terminal = (count_q == LAST);

endmodule

// File: rtl/alu_host_cmd_sender.sv
// Host-side ALU command sender: pushes OP, A, B into the TX FIFO, then pops one
// result byte from the RX FIFO or gives up after TIMEOUT_CYCLES.
module alu_host_cmd_sender
    import alu_host_cmd_sender_pkg::*;
#(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned NB_OP          = 6,
    parameter int unsigned NB_TIMEOUT     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [NB_OP-1:0]   i_cmd_op,
    input  logic [NB_DATA-1:0] i_cmd_a,
    input  logic [NB_DATA-1:0] i_cmd_b,
    output logic               o_tx_wr,
    output logic [NB_DATA-1:0] o_tx_wr_data,
    input  logic               i_tx_full,
    output logic               o_rx_rd,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_empty,
    output logic               o_res_valid,
    output logic [NB_DATA-1:0] o_res_data,
    output logic               o_res_timeout,
    output logic [7:0]         o_timeout_cnt,
    output logic               o_busy
);

    state_e               state_q, state_d;
    logic [NB_OP-1:0]     op_q, op_d;
    logic [NB_DATA-1:0]   a_q, a_d;
    logic [NB_DATA-1:0]   b_q, b_d;
    logic [NB_DATA-1:0]   res_data_q, res_data_d;
    logic                 res_valid_q, res_valid_d;
    logic                 res_timeout_q, res_timeout_d;
    logic [7:0]           timeout_cnt_q, timeout_cnt_d;
    logic                 tc_clear, tc_enable, tc_terminal;

    timeout_counter #(
        .NB_TIMEOUT     (NB_TIMEOUT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_counter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (tc_clear),
        .i_enable   (tc_enable),
        .o_terminal (tc_terminal)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        res_data_d    = res_data_q;
        res_valid_d   = 1'b0;
        res_timeout_d = 1'b0;
        timeout_cnt_d = timeout_cnt_q;
        o_tx_wr       = 1'b0;
        o_tx_wr_data  = '0;
        o_rx_rd       = 1'b0;
        tc_clear      = 1'b0;
        tc_enable     = 1'b0;
        o_cmd_ready   = (state_q == ST_IDLE) && i_rx_empty;

        case (state_q)
            ST_IDLE: begin
                // Stale bytes are drained before any new command is taken.
                if (!i_rx_empty) begin
                    o_rx_rd = 1'b1;
                end else if (i_cmd_valid) begin
                    op_d    = i_cmd_op;
                    a_d     = i_cmd_a;
                    b_d     = i_cmd_b;
                    state_d = ST_SEND_OP;
                end
            end
            ST_SEND_OP: begin
                o_tx_wr_data = NB_DATA'(op_q);
                o_tx_wr      = !i_tx_full;
                if (o_tx_wr) state_d = ST_SEND_A;
            end
            ST_SEND_A: begin
                o_tx_wr_data = a_q;
                o_tx_wr      = !i_tx_full;
                if (o_tx_wr) state_d = ST_SEND_B;
            end
            ST_SEND_B: begin
                o_tx_wr_data = b_q;
                o_tx_wr      = !i_tx_full;
                if (o_tx_wr) begin
                    tc_clear = 1'b1;
                    state_d  = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                // A byte present in the terminal-count cycle still counts as a result.
                if (!i_rx_empty) begin
                    o_rx_rd     = 1'b1;
                    res_data_d  = i_rx_data;
                    res_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    tc_enable = 1'b1;
                    if (tc_terminal) begin
                        res_timeout_d = 1'b1;
                        if (timeout_cnt_q != 8'hFF) timeout_cnt_d = timeout_cnt_q + 8'd1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (i_reset) begin
            o_tx_wr = 1'b0;
            o_rx_rd = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            res_data_q    <= '0;
            res_valid_q   <= 1'b0;
            res_timeout_q <= 1'b0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            res_data_q    <= res_data_d;
            res_valid_q   <= res_valid_d;
            res_timeout_q <= res_timeout_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign o_res_valid   = res_valid_q;
    assign o_res_data    = res_data_q;
    assign o_res_timeout = res_timeout_q;
    assign o_timeout_cnt = timeout_cnt_q;
    assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_host_cmd_sender.sv
// Directed bench for alu_host_cmd_sender with FIFO/responder models and a
// scoreboard of expected TX bytes and results.
module tb_alu_host_cmd_sender;
    import alu_host_cmd_sender_pkg::*;

    localparam int unsigned NB_DATA = 8;
    localparam int unsigned NB_OP   = 6;
    localparam int unsigned TO_CYC  = 16;

    typedef struct packed {
        logic       to;
        logic [7:0] data;
    } exp_t;

    logic               i_clk = 1'b0;
    logic               i_reset = 1'b1;
    logic               i_cmd_valid = 1'b0;
    logic               o_cmd_ready;
    logic [NB_OP-1:0]   i_cmd_op = '0;
    logic [NB_DATA-1:0] i_cmd_a = '0;
    logic [NB_DATA-1:0] i_cmd_b = '0;
    logic               o_tx_wr;
    logic [NB_DATA-1:0] o_tx_wr_data;
    logic               i_tx_full = 1'b0;
    logic               o_rx_rd;
    logic [NB_DATA-1:0] i_rx_data = '0;
    logic               i_rx_empty = 1'b1;
    logic               o_res_valid;
    logic [NB_DATA-1:0] o_res_data;
    logic               o_res_timeout;
    logic [7:0]         o_timeout_cnt;
    logic               o_busy;

    alu_host_cmd_sender #(
        .NB_DATA        (NB_DATA),
        .NB_OP          (NB_OP),
        .NB_TIMEOUT     (16),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_op      (i_cmd_op),
        .i_cmd_a       (i_cmd_a),
        .i_cmd_b       (i_cmd_b),
        .o_tx_wr       (o_tx_wr),
        .o_tx_wr_data  (o_tx_wr_data),
        .i_tx_full     (i_tx_full),
        .o_rx_rd       (o_rx_rd),
        .i_rx_data     (i_rx_data),
        .i_rx_empty    (i_rx_empty),
        .o_res_valid   (o_res_valid),
        .o_res_data    (o_res_data),
        .o_res_timeout (o_res_timeout),
        .o_timeout_cnt (o_timeout_cnt),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   full_from = 0, full_to = 0;
    int   acc_cyc = 0, res_cyc = 0, first_wr = -1, last_wr = 0;
    int   n_wr = 0, n_rd = 0;
    bit   accepted = 0, done = 0, ready_at_res = 0;
    bit   resp_enable = 1, resp_pending = 0;
    int   resp_delay = 1, resp_due = 0;
    logic [7:0] resp_val = '0;
    logic [7:0] rxq[$];
    logic [7:0] txexp[$];
    logic [7:0] txseen[$];
    exp_t       expq[$];

    function automatic logic [7:0] alu(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            ALU_OP_ADD: return a + b;
            ALU_OP_SUB: return a - b;
            ALU_OP_AND: return a & b;
            ALU_OP_OR:  return a | b;
            ALU_OP_XOR: return a ^ b;
            ALU_OP_NOR: return ~(a | b);
            ALU_OP_SRL: return a >> b;
            ALU_OP_SRA: return $signed(a) >>> b;
            default:    return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive FIFO-side inputs, settle, observe, wait for next negedge.
    task automatic cycle();
        exp_t e;
        if (resp_pending && cyc >= resp_due) begin
            rxq.push_back(resp_val);
            resp_pending = 0;
        end
        i_tx_full  = (cyc >= full_from) && (cyc < full_to);
        i_rx_empty = (rxq.size() == 0);
        i_rx_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
        #1;
        if (i_tx_full)   chk("wr_while_full", o_tx_wr, 0);
        if (i_rx_empty)  chk("rd_while_empty", o_rx_rd, 0);
        if (!i_rx_empty) chk("ready_while_rx_pending", o_cmd_ready, 0);
        if (i_reset) begin
            chk("wr_in_reset", o_tx_wr, 0);
            chk("rd_in_reset", o_rx_rd, 0);
        end
        if (o_tx_wr) begin
            n_wr++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (txexp.size() == 0) chk("tx_unexpected", o_tx_wr, 0);
            else chk("tx_byte", o_tx_wr_data, txexp.pop_front());
            txseen.push_back(o_tx_wr_data);
            if (txseen.size() == 3) begin
                resp_val = alu(txseen[0][5:0], txseen[1], txseen[2]);
                txseen.delete();
                if (resp_enable) begin
                    resp_pending = 1;
                    resp_due     = cyc + resp_delay;
                end
            end
        end
        if (o_rx_rd && rxq.size() != 0) begin
            void'(rxq.pop_front());
            n_rd++;
        end
        if (o_res_valid || o_res_timeout) begin
            chk("res_exclusive", o_res_valid & o_res_timeout, 0);
            res_cyc      = cyc;
            ready_at_res = o_cmd_ready;
            done         = 1;
            if (expq.size() == 0) chk("res_unexpected", o_res_valid | o_res_timeout, 0);
            else begin
                e = expq.pop_front();
                chk("res_kind_timeout", o_res_timeout, e.to);
                if (!e.to) chk("res_data", o_res_data, e.data);
            end
        end
        if (i_cmd_valid && o_cmd_ready) begin
            accepted = 1;
            acc_cyc  = cyc;
            first_wr = -1;
        end
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic send_cmd(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b, input bit exp_to);
        i_cmd_op    = op;
        i_cmd_a     = a;
        i_cmd_b     = b;
        i_cmd_valid = 1'b1;
        accepted    = 0;
        done        = 0;
        for (int k = 0; k < 50 && !accepted; k++) cycle();
        i_cmd_valid = 1'b0;
        chk("accept_seen", accepted, 1);
        if (accepted) begin
            txexp.push_back(8'(op));
            txexp.push_back(a);
            txexp.push_back(b);
            expq.push_back('{to: exp_to, data: alu(op, a, b)});
        end
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && !done; k++) cycle();
        chk("result_seen", done, 1);
    endtask

    int wr0, rd0, stale_cyc;
    logic [5:0] ops [8];

    initial begin
        ops = '{ALU_OP_ADD, ALU_OP_SUB, ALU_OP_AND, ALU_OP_OR,
                ALU_OP_XOR, ALU_OP_SRA, ALU_OP_SRL, ALU_OP_NOR};

        // Reset state
        i_reset = 1'b1;
        cycle();
        cycle();
        chk("rst_res_data", o_res_data, 0);
        chk("rst_res_valid", o_res_valid, 0);
        chk("rst_res_timeout", o_res_timeout, 0);
        chk("rst_timeout_cnt", o_timeout_cnt, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ready", o_cmd_ready, 1);
        i_reset = 1'b0;
        cycle();

        // 1: ADD 05+03, minimum latency
        resp_enable = 1; resp_delay = 1;
        send_cmd(ALU_OP_ADD, 8'h05, 8'h03, 0);
        wait_done(40);
        chk("t1_latency", res_cyc - acc_cyc, 5);
        chk("t1_tx_span", last_wr - first_wr, 2);
        chk("t1_ready_at_res", ready_at_res, 1);
        chk("t1_first_wr", first_wr - acc_cyc, 1);

        // 2: TX full for 4 cycles while in SEND_A
        wr0 = n_wr;
        send_cmd(ALU_OP_SUB, 8'h10, 8'h01, 0);
        full_from = acc_cyc + 2;
        full_to   = acc_cyc + 6;
        wait_done(40);
        chk("t2_latency", res_cyc - acc_cyc, 9);
        chk("t2_writes", n_wr - wr0, 3);
        chk("t2_res_data_held", o_res_data, 8'h0F);

        // 3: no response -> timeout
        resp_enable = 0;
        send_cmd(ALU_OP_AND, 8'hF0, 8'h3C, 1);
        wait_done(60);
        chk("t3_timeout_delay", res_cyc - acc_cyc, 4 + TO_CYC);
        chk("t3_timeout_cnt", o_timeout_cnt, 1);
        chk("t3_res_data_kept", o_res_data, 8'h0F);
        chk("t3_ready_at_pulse", ready_at_res, 1);
        chk("t3_busy_after", o_busy, 0);

        // 4: two stale RX bytes while a command is waiting
        resp_enable = 1; resp_delay = 1;
        rxq.push_back(8'hAA);
        rxq.push_back(8'hBB);
        rd0 = n_rd;
        stale_cyc = cyc;
        send_cmd(ALU_OP_XOR, 8'h33, 8'h0F, 0);
        chk("t4_stale_pops", n_rd - rd0, 2);
        chk("t4_accept_cycle", acc_cyc - stale_cyc, 2);
        wait_done(40);

        // 5: result arrives in the terminal-count cycle
        resp_delay = TO_CYC;
        send_cmd(ALU_OP_OR, 8'h0A, 8'h50, 0);
        wait_done(60);
        chk("t5_latency", res_cyc - acc_cyc, 4 + TO_CYC);
        chk("t5_timeout_cnt", o_timeout_cnt, 1);

        // 6: reset asserted in SEND_A
        resp_delay = 1;
        send_cmd(ALU_OP_ADD, 8'h01, 8'h02, 0);
        cycle();
        i_reset = 1'b1;
        cycle();
        i_reset = 1'b0;
        txexp.delete();
        expq.delete();
        txseen.delete();
        resp_pending = 0;
        #1;
        chk("t6_busy_after_reset", o_busy, 0);
        chk("t6_ready_after_reset", o_cmd_ready, 1);
        wr0 = n_wr;
        for (int k = 0; k < 4; k++) cycle();
        chk("t6_no_writes", n_wr - wr0, 0);
        send_cmd(ALU_OP_ADD, 8'h7F, 8'h01, 0);
        wait_done(40);
        chk("t6_res_data", o_res_data, 8'h80);

        // A few mixed commands with varying responder delay
        for (int k = 0; k < 6; k++) begin
            resp_delay = $urandom_range(1, 6);
            send_cmd(ops[k + 2], 8'($urandom), 8'($urandom_range(0, 7)), 0);
            wait_done(40);
            chk("mix_latency", res_cyc - acc_cyc, 4 + resp_delay);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
